// File: rtl/tri_pkg.sv
// Shared constants and FSM state encodings for the triangle pixel collector.
package tri_pkg;

  localparam int DEF_COORD_W = 3;
  localparam int DEF_GRID    = 1 << DEF_COORD_W;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_TAIL    = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  function automatic int grid_size(input int coord_w);
    return 1 << coord_w;
  endfunction

endpackage

// File: rtl/tri_bitmap_ram.sv
// Square one-bit bitmap: clear-all, single-bit set, read-before-set hit flag,
// and a whole-row read port. Clear has priority, then the set lands on top.
module tri_bitmap_ram
  import tri_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          set_en,
  input  logic [COORD_W-1:0]            set_x,
  input  logic [COORD_W-1:0]            set_y,
  input  logic [COORD_W-1:0]            rd_row,
  output logic                          hit,
  output logic [grid_size(COORD_W)-1:0] rd_data
);

  localparam int GRID = grid_size(COORD_W);

  logic [GRID*GRID-1:0] bits_flat;

  generate
    for (genvar gi = 0; gi < GRID; gi++) begin : g_row
      logic [GRID-1:0] row_reg;
      logic [GRID-1:0] row_next;

      always_comb begin
        row_next = clr ? '0 : row_reg;
        if (set_en && (set_y == COORD_W'(gi))) begin
          row_next[set_x] = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          row_reg <= '0;
        end else begin
          row_reg <= row_next;
        end
      end

      assign bits_flat[gi*GRID +: GRID] = row_reg;
    end
  endgenerate

  // {y,x} is exactly the flat bit index because GRID is a power of two.
  assign hit     = bits_flat[{set_y, set_x}];
  assign rd_data = bits_flat[{rd_row, {COORD_W{1'b0}}} +: GRID];

endmodule

// File: rtl/tri_pixel_collector.sv
// Captures the renderer pixel stream into a bitmap and drains it row by row.
// Optional TRI_PIX_DUP_CHECK_EN adds a sticky per-frame dup_err output.
module tri_pixel_collector
  import tri_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int TAIL_CYC = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          busy_i,
  input  logic                          po,
  input  logic [COORD_W-1:0]            xo,
  input  logic [COORD_W-1:0]            yo,
  input  logic                          row_ready,
  output logic                          row_valid,
  output logic [COORD_W-1:0]            row_idx,
  output logic [grid_size(COORD_W)-1:0] row_data,
  output logic                          frame_done,
  output logic [2*COORD_W:0]            pix_cnt,
  output logic                          overrun
`ifdef TRI_PIX_DUP_CHECK_EN
  ,
  output logic                          dup_err
`endif
);

  localparam int GRID = grid_size(COORD_W);
  localparam int PW   = 2*COORD_W + 1;
  localparam int TW   = $clog2(TAIL_CYC + 2);

  state_t          state;
  logic            busy_q;
  logic [TW-1:0]   tail_cnt;
  logic            rise;
  logic            fall;
  logic            clr;
  logic            cap;
  logic            hit;
  logic [GRID-1:0] rd_data;

  assign rise = busy_i & ~busy_q;
  assign fall = ~busy_i & busy_q;
  assign clr  = (state == ST_IDLE) && rise;
  // A pixel in the accepting rise cycle is written on top of the clear.
  assign cap  = po && (clr || (state == ST_COLLECT) || (state == ST_TAIL));

  tri_bitmap_ram #(.COORD_W(COORD_W)) u_bitmap (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .set_en  (cap),
    .set_x   (xo),
    .set_y   (yo),
    .rd_row  (row_idx),
    .hit     (hit),
    .rd_data (rd_data)
  );

  assign row_valid  = (state == ST_DRAIN);
  assign row_data   = rd_data;
  assign frame_done = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy_q   <= 1'b0;
      tail_cnt <= '0;
      row_idx  <= '0;
      pix_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      busy_q <= busy_i;

      if (clr) begin
        pix_cnt <= PW'(po);
      end else if (cap && !hit) begin
        pix_cnt <= pix_cnt + PW'(1);
      end

      // A new render while the previous frame is still in flight is dropped.
      if (rise && ((state == ST_TAIL) || (state == ST_DRAIN) || (state == ST_DONE))) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (rise) state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (fall) begin
            row_idx <= '0;
            if (TAIL_CYC == 0) begin
              state <= ST_DRAIN;
            end else begin
              tail_cnt <= TW'(TAIL_CYC);
              state    <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (tail_cnt == TW'(1)) begin
            row_idx <= '0;
            state   <= ST_DRAIN;
          end else begin
            tail_cnt <= tail_cnt - TW'(1);
          end
        end
        ST_DRAIN: begin
          if (row_ready) begin
            row_idx <= row_idx + COORD_W'(1);
            if (row_idx == COORD_W'(GRID-1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TRI_PIX_DUP_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dup_err <= 1'b0;
    end else if (clr) begin
      dup_err <= 1'b0;
    end else if ((state == ST_IDLE) && po) begin
      dup_err <= 1'b1;
    end else if (cap && hit) begin
      dup_err <= 1'b1;
    end
  end
`else
  // Duplicate pixels merge silently; pix_cnt still counts unique pixels.
`endif

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Scoreboard bench for tri_pixel_collector: expected rows are queued from a
// bitmap model and compared as the DUT drains them.
module tb_tri_pixel_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy_i;
  logic       po;
  logic [2:0] xo;
  logic [2:0] yo;
  logic       row_ready;
  logic       row_valid;
  logic [2:0] row_idx;
  logic [7:0] row_data;
  logic       frame_done;
  logic [6:0] pix_cnt;
  logic       overrun;
`ifdef TRI_PIX_DUP_CHECK_EN
  logic       dup_err;
`endif

  tri_pixel_collector #(.COORD_W(3), .TAIL_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .busy_i     (busy_i),
    .po         (po),
    .xo         (xo),
    .yo         (yo),
    .row_ready  (row_ready),
    .row_valid  (row_valid),
    .row_idx    (row_idx),
    .row_data   (row_data),
    .frame_done (frame_done),
    .pix_cnt    (pix_cnt),
    .overrun    (overrun)
`ifdef TRI_PIX_DUP_CHECK_EN
    ,
    .dup_err    (dup_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
  } row_t;

  row_t       exp_q[$];
  logic [5:0] stim[$];
  logic [7:0] bm[8];
  int         exp_cnt;
  bit         exp_dup;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] px(input int x, input int y);
    logic [2:0] xs;
    logic [2:0] ys;
    xs = x[2:0];
    ys = y[2:0];
    return {ys, xs};
  endfunction

  task automatic model_set(input logic [2:0] x, input logic [2:0] y);
    if (bm[y][x]) begin
      exp_dup = 1'b1;
    end else begin
      bm[y][x] = 1'b1;
      exp_cnt++;
    end
  endtask

  // One full frame: rise, pixels from stim, fall, optional tail/drain pixel at (7,7),
  // optional stall, optional rise during drain, optional reset after abort_at rows.
  task automatic run_frame(input bit tail_px, input bit drain_px, input int stall,
                           input bit rise_in_drain, input int abort_at);
    int   got;
    int   cyc;
    row_t e;
    @(negedge clk);
    busy_i = 1'b1;
    po     = 1'b0;
    for (int r = 0; r < 8; r++) bm[r] = 8'h00;
    exp_cnt = 0;
    exp_dup = 1'b0;
    foreach (stim[i]) begin
      @(negedge clk);
      po = 1'b1;
      {yo, xo} = stim[i];
      model_set(stim[i][2:0], stim[i][5:3]);
    end
    @(negedge clk);
    busy_i = 1'b0;
    po     = 1'b0;
    @(negedge clk);
    if (tail_px) begin
      po = 1'b1;
      xo = 3'd7;
      yo = 3'd7;
      model_set(3'd7, 3'd7);
    end
    @(negedge clk);
    po = 1'b0;
    for (int r = 0; r < 8; r++) exp_q.push_back('{idx: r[2:0], data: bm[r]});
    chk("drain_latency", row_valid, 1);
    chk("pix_cnt", pix_cnt, exp_cnt);
    if (drain_px) begin
      po = 1'b1;
      xo = 3'd7;
      yo = 3'd7;
    end
    if (rise_in_drain) busy_i = 1'b1;
    row_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", row_valid, 1);
      chk("stall_idx", row_idx, 0);
      chk("stall_data", row_data, exp_q[0].data);
      @(negedge clk);
      po = 1'b0;
    end
    row_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (cyc < 40 && got < 8) begin
      if (row_valid) begin
        if (got == abort_at) begin
          reset = 1'b1;
          #1;
          chk("rst_row_valid_now", row_valid, 0);
          @(negedge clk);
          chk("rst_row_valid", row_valid, 0);
          chk("rst_frame_done", frame_done, 0);
          chk("rst_pix_cnt", pix_cnt, 0);
          reset     = 1'b0;
          row_ready = 1'b0;
          exp_q.delete();
          @(negedge clk);
          chk("rst_no_frame_done", frame_done, 0);
          chk("rst_idle", row_valid, 0);
          return;
        end
        e = exp_q.pop_front();
        $display("row idx=%0d data=0x%02h exp_idx=%0d exp_data=0x%02h",
                 row_idx, row_data, e.idx, e.data);
        chk("row_idx", row_idx, e.idx);
        chk("row_data", row_data, e.data);
        got++;
      end
      @(negedge clk);
      po = 1'b0;
      cyc++;
    end
    if (got < 8) chk("drain_timeout", got, 8);
    chk("drain_cycles", cyc, 8);
    chk("frame_done_pulse", frame_done, 1);
    chk("done_row_valid", row_valid, 0);
    @(negedge clk);
    row_ready = 1'b0;
    chk("frame_done_end", frame_done, 0);
    chk("idle_row_valid", row_valid, 0);
    chk("idle_pix_cnt", pix_cnt, exp_cnt);
    if (rise_in_drain) chk("overrun", overrun, 1);
`ifdef TRI_PIX_DUP_CHECK_EN
    chk("dup_err", dup_err, exp_dup);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held_cnt;
    reset     = 1'b1;
    busy_i    = 1'b0;
    po        = 1'b0;
    xo        = 3'd0;
    yo        = 3'd0;
    row_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_row_valid", row_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_pix_cnt", pix_cnt, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_row_idx", row_idx, 0);
    chk("reset_row_data", row_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-drain, then an empty render reads back all zeros.
    stim = '{px(1, 1), px(4, 6)};
    run_frame(1'b0, 1'b0, 0, 1'b0, 3);
    stim = '{};
    run_frame(1'b0, 1'b0, 0, 1'b0, -1);

    stim = '{px(0, 0), px(1, 0), px(0, 1)};
    run_frame(1'b0, 1'b0, 0, 1'b0, -1);

    stim = '{px(2, 3), px(2, 3), px(5, 3)};
    run_frame(1'b0, 1'b0, 0, 1'b0, -1);

    // Pixel one cycle after the fall is kept; two cycles after is dropped.
    stim = '{px(3, 2)};
    run_frame(1'b1, 1'b0, 0, 1'b0, -1);
    stim = '{px(0, 7)};
    run_frame(1'b0, 1'b1, 0, 1'b0, -1);

    stim = '{px(6, 0), px(1, 5)};
    run_frame(1'b0, 1'b0, 5, 1'b0, -1);
    chk("no_overrun_yet", overrun, 0);

    // Rise during drain: overrun, frame completes, no capture afterwards.
    stim = '{px(4, 4), px(7, 0)};
    run_frame(1'b0, 1'b0, 0, 1'b1, -1);
    held_cnt = exp_cnt;
    po = 1'b1;
    xo = 3'd3;
    yo = 3'd3;
    exp_dup = 1'b1;
    @(negedge clk);
    @(negedge clk);
    po = 1'b0;
    @(negedge clk);
    chk("dropped_pix_cnt", pix_cnt, held_cnt);
    chk("dropped_row_valid", row_valid, 0);
`ifdef TRI_PIX_DUP_CHECK_EN
    chk("idle_po_dup_err", dup_err, exp_dup);
`endif
    busy_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("overrun_sticky", overrun, 1);

    stim = '{px(5, 5)};
    run_frame(1'b0, 1'b0, 0, 1'b0, -1);
    chk("overrun_sticky_after", overrun, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
